// File: rtl/stf_pkg.sv
// Shared defaults and types for the slow-to-fast sample FIFO.
// No logic; constants, types and a pointer-width helper only.
// Imported by stf_fifo_core and stf_sample_fifo.
package stf_pkg;

  localparam int STF_FIFO_DEPTH_DEF = 8;
  localparam int STF_PAYLOAD_W_DEF  = 16;

  typedef logic [7:0] ovf_cnt_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stf_fifo_core.sv
// Circular buffer with wrap-bit pointers and a registered head-of-queue read port.
// Latency: a write into an empty buffer is visible after the next edge; pops advance the head in one edge.
// Backpressure: caller gates wr_en against full and rd_en against rd_valid; no internal protection.
module stf_fifo_core
  import stf_pkg::*;
#(
  parameter int W     = STF_PAYLOAD_W_DEF,
  parameter int DEPTH = STF_FIFO_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic [ptr_w(DEPTH)-1:0]    level
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr, wptr_n, rptr_n;

  assign full   = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign wptr_n = wr_en ? wptr + PW'(1) : wptr;
  assign rptr_n = rd_en ? rptr + PW'(1) : rptr;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= wr_data;
  end

  // Head register looks ahead to the next read pointer; a write landing on
  // that slot this edge is forwarded so an empty queue shows it immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      wptr     <= wptr_n;
      rptr     <= rptr_n;
      level    <= wptr_n - rptr_n;
      rd_valid <= (wptr_n != rptr_n);
      rd_data  <= (wr_en && (wptr[AW-1:0] == rptr_n[AW-1:0])) ? wr_data
                                                               : mem[rptr_n[AW-1:0]];
    end
  end

endmodule

// File: rtl/stf_sample_fifo.sv
// Captures one payload per toggle flip on the synchronized bus into a FIFO; ovf_count exists with STF_FIFO_OVF_COUNT_EN.
// Latency: 2 fastclk cycles from toggle sampled on synced to out_valid when empty.
// Backpressure: out_valid/out_ready stream; samples arriving while full (and not popping) are dropped and flagged.
module stf_sample_fifo
  import stf_pkg::*;
#(
  parameter int W     = STF_PAYLOAD_W_DEF,
  parameter int DEPTH = STF_FIFO_DEPTH_DEF
) (
  input  logic                     fastclk,
  input  logic                     reset_n,
  input  logic [W:0]               synced,
  output logic [W-1:0]             out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ptr_w(DEPTH)-1:0]  level,
  output logic                     ovf,
  input  logic                     ovf_clr
`ifdef STF_FIFO_OVF_COUNT_EN
  ,
  output ovf_cnt_t                 ovf_count
`endif
);

  logic [W:0] in_q;
  logic       tog_q;
  logic       armed;
  logic       push;
  logic       pop;
  logic       full;
  logic       wr_en;
  logic       ovf_set;

  assign push    = armed && (in_q[W] != tog_q);
  assign pop     = out_valid && out_ready;
  assign wr_en   = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  // The arming edge seeds tog_q from the value entering in_q, so a toggle
  // level already present at reset release is never mistaken for a flip.
  always_ff @(posedge fastclk or negedge reset_n) begin
    if (!reset_n) begin
      in_q  <= '0;
      tog_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      in_q <= synced;
      if (!armed) begin
        armed <= 1'b1;
        tog_q <= synced[W];
      end else if (push) begin
        tog_q <= in_q[W];
      end
    end
  end

  always_ff @(posedge fastclk or negedge reset_n) begin
    if (!reset_n)     ovf <= 1'b0;
    else if (ovf_set) ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

`ifdef STF_FIFO_OVF_COUNT_EN
  always_ff @(posedge fastclk or negedge reset_n) begin
    if (!reset_n)                           ovf_count <= '0;
    else if (ovf_clr)                       ovf_count <= ovf_set ? 8'd1 : 8'd0;
    else if (ovf_set && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
  end
`endif

  stf_fifo_core #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_core (
    .clk      (fastclk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_data  (in_q[W-1:0]),
    .rd_en    (pop),
    .rd_data  (out_data),
    .rd_valid (out_valid),
    .full     (full),
    .level    (level)
  );

endmodule

// File: tb/tb_stf_sample_fifo.sv
// Randomized and directed bench for stf_sample_fifo against a queue-based sample model.
module tb_stf_sample_fifo;

  localparam int W     = 16;
  localparam int DEPTH = 8;

  logic          fastclk = 1'b0;
  logic          reset_n = 1'b0;
  logic [W:0]    synced  = '0;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [3:0]    level;
  logic          ovf;
  logic          ovf_clr   = 1'b0;
`ifdef STF_FIFO_OVF_COUNT_EN
  logic [7:0]    ovf_count;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 fastclk = ~fastclk;

  stf_sample_fifo #(.W(W), .DEPTH(DEPTH)) dut (
    .fastclk   (fastclk),
    .reset_n   (reset_n),
    .synced    (synced),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
`ifdef STF_FIFO_OVF_COUNT_EN
    ,
    .ovf_count (ovf_count)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Sample-level model: a push happens one edge after two consecutive samples
  // of synced differ in the toggle bit (not counting the first sample after reset).
  logic [W-1:0] mq[$];
  logic         m_ovf = 1'b0;
  int           m_cnt = 0;
  int           nedge = 0;
  logic         prev_tog = 1'b0;
  logic         pend = 1'b0;
  logic [W-1:0] pend_d = '0;

  initial begin
    forever begin
      @(posedge fastclk);
      if (!reset_n) begin
        mq.delete();
        m_ovf = 1'b0; m_cnt = 0; nedge = 0; pend = 1'b0;
      end else begin
        bit m_pop, m_drop;
        nedge++;
        m_pop  = (mq.size() > 0) && out_ready;
        m_drop = pend && (mq.size() == DEPTH) && !m_pop;
        if (m_pop) void'(mq.pop_front());
        if (pend && !m_drop) mq.push_back(pend_d);
        if (ovf_clr) m_cnt = m_drop ? 1 : 0;
        else if (m_drop && m_cnt < 255) m_cnt++;
        if (m_drop) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        pend   = (nedge >= 2) && (synced[W] != prev_tog);
        pend_d = synced[W-1:0];
        prev_tog = synced[W];
      end
      #1;
      chk("valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("level", 32'(level), mq.size());
      chk("ovf", 32'(ovf), 32'(m_ovf));
`ifdef STF_FIFO_OVF_COUNT_EN
      chk("ovf_count", 32'(ovf_count), m_cnt);
`endif
      if (mq.size() != 0) chk("data", 32'(out_data), 32'(mq[0]));
    end
  end

  task automatic send(input logic [W-1:0] d, input int hold);
    synced = {~synced[W], d};
    repeat (hold) @(negedge fastclk);
  endtask

  task automatic drain_expect(input logic [W-1:0] base, input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      chk({nm, "_v"}, 32'(out_valid), 32'd1);
      chk({nm, "_d"}, 32'(out_data), 32'(base + W'(i)));
      out_ready = 1'b1;
      @(negedge fastclk);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    synced = {1'b1, 16'hBEEF};
    repeat (3) @(negedge fastclk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge fastclk);
      chk("static_level", 32'(level), 32'd0);
    end

    // Fresh start with toggle low, then a single 0->1 flip
    reset_n = 1'b0; synced = '0;
    @(negedge fastclk);
    reset_n = 1'b1;
    repeat (4) @(negedge fastclk);
    synced = {1'b1, 16'h1234};
    @(posedge fastclk); #1;
    chk("lat1_valid", 32'(out_valid), 32'd0);
    @(posedge fastclk); #1;
    chk("lat2_valid", 32'(out_valid), 32'd1);
    chk("lat2_data", 32'(out_data), 32'h1234);
    chk("lat2_level", 32'(level), 32'd1);
    @(negedge fastclk);
    out_ready = 1'b1;
    @(negedge fastclk);
    out_ready = 1'b0;

    // Repeated identical payloads
    repeat (3) send(16'h00AA, 4);
    repeat (2) @(negedge fastclk);
    chk("same_level", 32'(level), 32'd3);
    drain_expect(16'h00AA, 1, "same0");
    drain_expect(16'h00AA, 1, "same1");
    drain_expect(16'h00AA, 1, "same2");
    chk("same_empty", 32'(out_valid), 32'd0);

    // Overflow: nine samples into eight slots
    for (int i = 0; i < 9; i++) send(16'h0100 + 16'(i), 4);
    repeat (2) @(negedge fastclk);
    chk("ovf_flag", 32'(ovf), 32'd1);
    chk("ovf_level", 32'(level), 32'd8);
`ifdef STF_FIFO_OVF_COUNT_EN
    chk("ovf_cnt1", 32'(ovf_count), 32'd1);
`endif
    drain_expect(16'h0100, 8, "ovf_drain");
    chk("ovf_empty", 32'(out_valid), 32'd0);

    // Clear, refill, then push and pop on the same edge while full
    ovf_clr = 1'b1;
    @(negedge fastclk);
    ovf_clr = 1'b0;
    chk("clr_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 8; i++) send(16'h0200 + 16'(i), 4);
    synced = {~synced[W], 16'h02FF};
    @(negedge fastclk);
    out_ready = 1'b1;
    @(negedge fastclk);
    out_ready = 1'b0;
    chk("fullpp_level", 32'(level), 32'd8);
    chk("fullpp_ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge fastclk);
    drain_expect(16'h0201, 7, "fullpp");
    drain_expect(16'h02FF, 1, "fullpp_last");

    // Clear coincident with a new overflow: set wins
    for (int i = 0; i < 8; i++) send(16'h0300 + 16'(i), 4);
    synced = {~synced[W], 16'h03FF};
    @(negedge fastclk);
    ovf_clr = 1'b1;
    @(negedge fastclk);
    ovf_clr = 1'b0;
    chk("clrset_ovf", 32'(ovf), 32'd1);
`ifdef STF_FIFO_OVF_COUNT_EN
    chk("clrset_cnt", 32'(ovf_count), 32'd1);
`endif
    drain_expect(16'h0300, 8, "clrset");

    // Reset in the middle of a fill
    for (int i = 0; i < 5; i++) send(16'h0400 + 16'(i), 4);
    chk("mid_level", 32'(level), 32'd5);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge fastclk);
    reset_n = 1'b1;
    repeat (3) @(negedge fastclk);
    send(16'h04AA, 4);
    chk("post_rst_level", 32'(level), 32'd1);
    chk("post_rst_data", 32'(out_data), 32'h04AA);

    // Random samples, random consumer stalls and clears
    for (int t = 0; t < 400; t++) begin
      int hold;
      synced = {~synced[W], 16'($urandom)};
      hold = $urandom_range(4, 7);
      repeat (hold) begin
        out_ready = ($urandom_range(0, 9) < 3);
        ovf_clr   = ($urandom_range(0, 19) == 0);
        @(negedge fastclk);
      end
    end
    ovf_clr = 1'b0;
    out_ready = 1'b1;
    repeat (12) @(negedge fastclk);
    out_ready = 1'b0;
    chk("final_empty", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
